sauria_cfg_sequencer: RTL and testbench

- AXI4-Lite configuration master that sits directly upstream of the SAURIA test wrapper's cfg_bus_lite port and drives it.
- Consumes a stream of 67-bit commands:
  - register writes;
  - register polls;
  - waits on interrupts;
  - DRAM check requests, which drive check_flag, dram_startoffs and dram_endoffs.
- Lets a bench run a whole test program from a command file with no bus-level code.

---
 rtl/sauria_cfg_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_sauria_cfg_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sauria_cfg_sequencer.sv
// rtl/sauria_cfg_sequencer.sv - command-driven AXI4-Lite configuration master for the SAURIA test wrapper
module sauria_cfg_sequencer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CHECK_HOLD     = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_data,
    output logic [31:0]      m_ar_addr,
    output logic             m_ar_valid,
    input  logic             m_ar_ready,
    input  logic [31:0]      m_r_data,
    input  logic             m_r_valid,
    output logic             m_r_ready,
    output logic [31:0]      m_aw_addr,
    output logic             m_aw_valid,
    input  logic             m_aw_ready,
    output logic [31:0]      m_w_data,
    output logic             m_w_valid,
    input  logic             m_w_ready,
    input  logic             ctrl_interrupt,
    input  logic             sauria_interrupt,
    input  logic             dma_interrupt,
    output logic             check_flag,
    output logic [31:0]      dram_startoffs,
    output logic [31:0]      dram_endoffs,
    output logic             done,
    output logic             timeout_err,
    output logic             op_err,
    output logic [CNT_W-1:0] cmd_count
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_AR, S_RD_R, S_IRQ, S_CHK, S_FIN} state_t;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_POLL  = 3'd1;
    localparam logic [2:0] OP_IRQ   = 3'd2;
    localparam logic [2:0] OP_CHECK = 3'd3;
    localparam logic [2:0] OP_END   = 3'd4;

    state_t      r_state;
    logic [31:0] r_data;
    logic [31:0] r_tmo;
    logic [15:0] r_chk;

    logic        w_accept;
    logic [31:0] w_tmo_next;
    logic        w_tmo_hit;
    logic        w_poll_ok;
    logic        w_aw_fin;
    logic        w_w_fin;
    logic        w_irq_sel;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_tmo_next = r_tmo + 32'd1;
    assign w_tmo_hit  = (w_tmo_next >= 32'(TIMEOUT_CYCLES));
    assign w_poll_ok  = ((m_r_data & r_data) == r_data);
    // A write channel is finished once its valid has dropped or it handshakes now
    assign w_aw_fin   = !m_aw_valid || m_aw_ready;
    assign w_w_fin    = !m_w_valid || m_w_ready;

    always_comb begin
        case (r_data[1:0])
            2'd0:    w_irq_sel = ctrl_interrupt;
            2'd1:    w_irq_sel = sauria_interrupt;
            default: w_irq_sel = dma_interrupt;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_state        <= S_IDLE;
            r_data         <= '0;
            r_tmo          <= '0;
            r_chk          <= '0;
            cmd_ready      <= 1'b0;
            m_ar_addr      <= '0;
            m_ar_valid     <= 1'b0;
            m_r_ready      <= 1'b0;
            m_aw_addr      <= '0;
            m_aw_valid     <= 1'b0;
            m_w_data       <= '0;
            m_w_valid      <= 1'b0;
            check_flag     <= 1'b0;
            dram_startoffs <= '0;
            dram_endoffs   <= '0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
            op_err         <= 1'b0;
            cmd_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        cmd_ready <= 1'b0;
                        r_data    <= cmd_data;
                        r_tmo     <= '0;
                        case (cmd_op)
                            OP_WRITE: begin
                                m_aw_addr  <= cmd_addr;
                                m_w_data   <= cmd_data;
                                m_aw_valid <= 1'b1;
                                m_w_valid  <= 1'b1;
                                r_state    <= S_WR;
                            end
                            OP_POLL: begin
                                m_ar_addr  <= cmd_addr;
                                m_ar_valid <= 1'b1;
                                r_state    <= S_RD_AR;
                            end
                            OP_IRQ: begin
                                if (cmd_data[1:0] == 2'd3) begin
                                    op_err  <= 1'b1;
                                    done    <= 1'b1;
                                    r_state <= S_FIN;
                                end else begin
                                    r_state <= S_IRQ;
                                end
                            end
                            OP_CHECK: begin
                                dram_startoffs <= cmd_addr;
                                dram_endoffs   <= cmd_data;
                                r_chk          <= '0;
                                r_state        <= S_CHK;
                            end
                            OP_END: begin
                                done      <= 1'b1;
                                cmd_count <= cmd_count + CNT_W'(1);
                                r_state   <= S_FIN;
                            end
                            default: begin
                                op_err  <= 1'b1;
                                done    <= 1'b1;
                                r_state <= S_FIN;
                            end
                        endcase
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_WR: begin
                    if (m_aw_ready) m_aw_valid <= 1'b0;
                    if (m_w_ready)  m_w_valid  <= 1'b0;
                    if (w_aw_fin && w_w_fin) begin
                        cmd_count <= cmd_count + CNT_W'(1);
                        cmd_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_RD_AR: begin
                    r_tmo <= w_tmo_next;
                    if (w_tmo_hit) begin
                        m_ar_valid  <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        r_state     <= S_FIN;
                    end else if (m_ar_ready) begin
                        m_ar_valid <= 1'b0;
                        m_r_ready  <= 1'b1;
                        r_state    <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    r_tmo <= w_tmo_next;
                    // A passing read on the timeout cycle still counts as success
                    if (m_r_valid && w_poll_ok) begin
                        m_r_ready <= 1'b0;
                        cmd_count <= cmd_count + CNT_W'(1);
                        cmd_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_tmo_hit) begin
                        m_r_ready   <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        r_state     <= S_FIN;
                    end else if (m_r_valid) begin
                        m_r_ready  <= 1'b0;
                        m_ar_valid <= 1'b1;
                        r_state    <= S_RD_AR;
                    end
                end
                S_IRQ: begin
                    r_tmo <= w_tmo_next;
                    if (w_irq_sel) begin
                        cmd_count <= cmd_count + CNT_W'(1);
                        cmd_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_tmo_hit) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        r_state     <= S_FIN;
                    end
                end
                S_CHK: begin
                    // Offsets were loaded on entry, so the flag rises a cycle after them
                    if (!check_flag) begin
                        check_flag <= 1'b1;
                        r_chk      <= '0;
                    end else if (r_chk == 16'(CHECK_HOLD - 1)) begin
                        check_flag <= 1'b0;
                        cmd_count  <= cmd_count + CNT_W'(1);
                        cmd_ready  <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_chk <= r_chk + 16'd1;
                    end
                end
                S_FIN: begin
                    cmd_ready <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sauria_cfg_sequencer.sv
// tb/tb_sauria_cfg_sequencer.sv - scoreboard bench for sauria_cfg_sequencer
module tb_sauria_cfg_sequencer;

    localparam int EV_AW = 1, EV_W = 2, EV_AR = 3, EV_CHK = 4, EV_RDY = 5, EV_DONE = 6;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } ev_t;

    logic        clk_sys = 1'b0;
    logic        rst_sys = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] m_ar_addr;
    logic        m_ar_valid;
    logic        m_ar_ready = 1'b0;
    logic [31:0] m_r_data = '0;
    logic        m_r_valid = 1'b0;
    logic        m_r_ready;
    logic [31:0] m_aw_addr;
    logic        m_aw_valid;
    logic        m_aw_ready = 1'b0;
    logic [31:0] m_w_data;
    logic        m_w_valid;
    logic        m_w_ready = 1'b0;
    logic        ctrl_interrupt = 1'b0;
    logic        sauria_interrupt = 1'b0;
    logic        dma_interrupt = 1'b0;
    logic        check_flag;
    logic [31:0] dram_startoffs;
    logic [31:0] dram_endoffs;
    logic        done;
    logic        timeout_err;
    logic        op_err;
    logic [15:0] cmd_count;

    sauria_cfg_sequencer #(
        .TIMEOUT_CYCLES(50),
        .CHECK_HOLD(4),
        .CNT_W(16)
    ) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_data(m_r_data), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(m_w_data), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
        .ctrl_interrupt(ctrl_interrupt), .sauria_interrupt(sauria_interrupt),
        .dma_interrupt(dma_interrupt),
        .check_flag(check_flag), .dram_startoffs(dram_startoffs), .dram_endoffs(dram_endoffs),
        .done(done), .timeout_err(timeout_err), .op_err(op_err), .cmd_count(cmd_count)
    );

    always #5 clk_sys = ~clk_sys;

    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [31:0] rd_vals[8];
    int          rd_n = 0, rd_idx = 0;

    function automatic string ev_name(int k);
        case (k)
            EV_AW:   return "aw_hs";
            EV_W:    return "w_hs";
            EV_AR:   return "ar_hs";
            EV_CHK:  return "check_pulse";
            EV_RDY:  return "cmd_complete";
            EV_DONE: return "program_done";
            default: return "unknown";
        endcase
    endfunction

    function automatic void expect_ev(int k, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endfunction

    task automatic mon_cmp(int k, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s actual a=%h b=%h c=%0d required no event", ev_name(k), a, b, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.b !== b || e.c !== c)
                begin
                failures++;
                $display("FAIL %s actual %s a=%h b=%h c=%0d required %s a=%h b=%h c=%0d",
                         ev_name(e.kind), ev_name(k), a, b, c, ev_name(e.kind), e.a, e.b, e.c);
            end
        end
    endtask

    task automatic check_val(string name, logic [191:0] act, logic [191:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Slave model: per-channel ready delays and a table of read responses
    initial begin
        int  aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
        logic r_hs;
        forever begin
            @(negedge clk_sys);
            r_hs = m_r_valid && m_r_ready;
            @(posedge clk_sys);
            #1;
            if (r_hs) rd_idx++;
            aw_cnt = m_aw_valid ? aw_cnt + 1 : 0;
            w_cnt  = m_w_valid  ? w_cnt + 1  : 0;
            ar_cnt = m_ar_valid ? ar_cnt + 1 : 0;
            m_aw_ready = m_aw_valid && (aw_cnt > aw_delay);
            m_w_ready  = m_w_valid  && (w_cnt > w_delay);
            m_ar_ready = m_ar_valid && (ar_cnt > ar_delay);
            m_r_valid  = m_r_ready && (rd_idx < rd_n);
            m_r_data   = (rd_idx < rd_n) ? rd_vals[rd_idx] : 32'h0;
        end
    end

    // Monitor: turns DUT activity into events and scores them against the queue
    initial begin
        int          since = 0, ar_n = 0, flag_len = 0;
        logic        busy = 1'b0, prev_ready = 1'b0, prev_done = 1'b0, prev_flag = 1'b0;
        logic [31:0] prev_start = '0, prev_end = '0, s0 = '0, e0 = '0;
        forever begin
            @(negedge clk_sys);
            if (rst_sys) begin
                busy = 1'b0; prev_ready = 1'b0; prev_done = 1'b0; prev_flag = 1'b0;
                prev_start = '0; prev_end = '0;
            end else begin
                since++;
                if (m_aw_valid && m_aw_ready) mon_cmp(EV_AW, m_aw_addr, 32'h0, since);
                if (m_w_valid && m_w_ready)   mon_cmp(EV_W, m_w_data, 32'h0, since);
                if (m_ar_valid && m_ar_ready) begin
                    ar_n++;
                    mon_cmp(EV_AR, m_ar_addr, 32'h0, ar_n);
                end
                if (check_flag) begin
                    if (!prev_flag) begin
                        s0 = prev_start; e0 = prev_end; flag_len = 0;
                    end
                    flag_len++;
                end else if (prev_flag) begin
                    mon_cmp(EV_CHK, s0, e0, flag_len);
                end
                if (busy && cmd_ready && !prev_ready) begin
                    mon_cmp(EV_RDY, 32'(cmd_count), {29'h0, timeout_err, op_err, done}, since);
                    busy = 1'b0;
                end
                if (busy && done && !prev_done) begin
                    mon_cmp(EV_DONE, 32'(cmd_count), {29'h0, timeout_err, op_err, done}, since);
                    busy = 1'b0;
                end
                if (cmd_valid && cmd_ready) begin
                    busy = 1'b1; since = 0; ar_n = 0;
                end
                prev_ready = cmd_ready; prev_done = done; prev_flag = check_flag;
                prev_start = dram_startoffs; prev_end = dram_endoffs;
            end
        end
    end

    task automatic send_cmd(logic [2:0] op, logic [31:0] addr, logic [31:0] data);
        bit ok = 1'b0;
        @(posedge clk_sys);
        #1;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_sys);
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept op=%0d actual cmd_ready=0 required handshake within 50 cycles", op);
        end
    endtask

    task automatic wait_drain(string name, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual pending=%0d required 0 within %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    function automatic logic [191:0] all_outputs();
        return {7'h0, cmd_ready, m_ar_addr, m_ar_valid, m_r_ready, m_aw_addr, m_aw_valid,
                m_w_data, m_w_valid, check_flag, dram_startoffs, dram_endoffs,
                done, timeout_err, op_err, cmd_count};
    endfunction

    task automatic do_reset(string name);
        @(posedge clk_sys);
        #1;
        rst_sys = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check_val(name, all_outputs(), 192'h0);
        @(posedge clk_sys);
        #1;
        rst_sys = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit stayed;
        repeat (2) @(posedge clk_sys);
        do_reset("reset_state");

        // WRITE with AW held off three cycles past W
        aw_delay = 3;
        expect_ev(EV_W,   32'hDEADBEEF, 32'h0, 1);
        expect_ev(EV_AW,  32'h10,       32'h0, 4);
        expect_ev(EV_RDY, 1,            32'h0, 5);
        send_cmd(3'd0, 32'h10, 32'hDEADBEEF);
        wait_drain("write_delayed", 40);
        aw_delay = 0;

        // POLL that needs three reads
        rd_vals[0] = 32'h1; rd_vals[1] = 32'h1; rd_vals[2] = 32'h7;
        rd_idx = 0; rd_n = 3;
        expect_ev(EV_AR, 32'h4, 32'h0, 1);
        expect_ev(EV_AR, 32'h4, 32'h0, 2);
        expect_ev(EV_AR, 32'h4, 32'h0, 3);
        expect_ev(EV_RDY, 2, 32'h0, 7);
        send_cmd(3'd1, 32'h4, 32'h3);
        wait_drain("poll", 40);

        expect_ev(EV_CHK, 32'h100, 32'h1FF, 4);
        expect_ev(EV_RDY, 3, 32'h0, 6);
        send_cmd(3'd3, 32'h100, 32'h1FF);
        wait_drain("check", 40);

        // Interrupt already high completes after one cycle in IRQ
        sauria_interrupt = 1'b1;
        expect_ev(EV_RDY, 4, 32'h0, 2);
        send_cmd(3'd2, 32'h0, 32'h1);
        wait_drain("irq_level", 20);
        sauria_interrupt = 1'b0;

        expect_ev(EV_DONE, 4, 32'h5, 51);
        send_cmd(3'd2, 32'h0, 32'h2);
        wait_drain("irq_timeout", 100);

        // Reset while the poll waits in RD_R for a read that never comes
        do_reset("reset_after_timeout");
        rd_idx = 0; rd_n = 0;
        expect_ev(EV_AR, 32'h8, 32'h0, 1);
        send_cmd(3'd1, 32'h8, 32'h1);
        wait_drain("poll_stall", 20);
        repeat (2) @(negedge clk_sys);
        check_val("in_rd_r", {191'h0, m_r_ready}, 192'h1);
        do_reset("reset_mid_rd_r");

        expect_ev(EV_AW,  32'h20,       32'h0, 1);
        expect_ev(EV_W,   32'h12345678, 32'h0, 1);
        expect_ev(EV_RDY, 1,            32'h0, 2);
        send_cmd(3'd0, 32'h20, 32'h12345678);
        wait_drain("write_after_reset", 20);

        expect_ev(EV_DONE, 2, 32'h1, 1);
        send_cmd(3'd4, 32'h0, 32'h0);
        wait_drain("end", 20);
        stayed = 1'b1;
        repeat (5) begin
            @(negedge clk_sys);
            if (cmd_ready || !done) stayed = 1'b0;
        end
        check_val("end_holds", {191'h0, stayed}, 192'h1);

        do_reset("reset_after_end");
        expect_ev(EV_DONE, 0, 32'h3, 1);
        send_cmd(3'd6, 32'h0, 32'h0);
        wait_drain("reserved_op", 20);

        do_reset("reset_after_reserved");
        expect_ev(EV_DONE, 0, 32'h3, 1);
        send_cmd(3'd2, 32'h0, 32'h3);
        wait_drain("irq_sel3", 20);

        repeat (3) @(negedge clk_sys);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
